// File: rtl/paillier_sched_pkg.sv
// rtl/paillier_sched_pkg.sv - shared state codes and size defaults for the Paillier encryption scheduler
package paillier_sched_pkg;

    localparam int PS_K = 128;
    localparam int PS_N = 32;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ME1_START = 4'd1,
        S_ME1_LOAD  = 4'd2,
        S_ME1_WAIT  = 4'd3,
        S_ME2_START = 4'd4,
        S_ME2_LOAD  = 4'd5,
        S_ME2_WAIT  = 4'd6,
        S_MM_START  = 4'd7,
        S_MM_LOAD   = 4'd8,
        S_MM_WAIT   = 4'd9
    } sched_state_t;

endpackage

// File: rtl/paillier_word_buf.sv
// rtl/paillier_word_buf.sv - N x K one-write one-read word buffer with registered read
module paillier_word_buf #(
    parameter int K  = 128,
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [K-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [K-1:0]  rd_data
);

    logic [K-1:0] mem [N];

    // Storage is left unreset so it can map onto RAM; only the read port register resets.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/paillier_enc_sched.sv
// rtl/paillier_enc_sched.sv - ME1/ME2/MM sequencer for Paillier encryption; optional watchdog via PAILLIER_ENC_SCHED_TIMEOUT_EN
module paillier_enc_sched
    import paillier_sched_pkg::*;
#(
    parameter int K = PS_K,
    parameter int N = PS_N
`ifdef PAILLIER_ENC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         task_start,
    output logic         busy,
    input  logic [K-1:0] in_x,
    input  logic [K-1:0] in_y,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [3:0]   state_now,
    output logic         me_start,
    output logic [K-1:0] me_x,
    output logic [K-1:0] me_y,
    output logic         me_x_valid,
    output logic         me_y_valid,
    input  logic [K-1:0] me_result,
    input  logic         me_valid,
    output logic         mm_start,
    output logic [K-1:0] mm_x,
    output logic [K-1:0] mm_y,
    output logic         mm_x_valid,
    output logic         mm_y_valid,
    input  logic [K-1:0] mm_result,
    input  logic         mm_valid,
    output logic [K-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sched_state_t  state, state_nxt;
    logic [CW-1:0] wcnt, rcnt;
    logic          in_acc, me_wr, mm_rd, mm_acc, timeout;
    logic          is_start, me_strobe, mm_strobe;

    assign in_ready  = (state == S_ME1_LOAD) || (state == S_ME2_LOAD);
    assign in_acc    = in_valid && in_ready;
    assign me_wr     = me_valid && ((state == S_ME1_WAIT) || (state == S_ME2_WAIT));
    assign mm_rd     = (state == S_MM_LOAD);
    assign mm_acc    = mm_valid && (state == S_MM_WAIT);
    assign me_start  = (state == S_ME1_START) || (state == S_ME2_START);
    assign mm_start  = (state == S_MM_START);
    assign is_start  = me_start || mm_start;
    assign state_now = state;
    // Stay busy through the out_last cycle so the host sees busy drop after it.
    assign busy      = (state != S_IDLE) || out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (task_start) state_nxt = S_ME1_START;
            S_ME1_START: state_nxt = S_ME1_LOAD;
            S_ME1_LOAD:  if (in_acc && wcnt == LAST) state_nxt = S_ME1_WAIT;
            S_ME1_WAIT:  if (me_wr && rcnt == LAST) state_nxt = S_ME2_START;
            S_ME2_START: state_nxt = S_ME2_LOAD;
            S_ME2_LOAD:  if (in_acc && wcnt == LAST) state_nxt = S_ME2_WAIT;
            S_ME2_WAIT:  if (me_wr && rcnt == LAST) state_nxt = S_MM_START;
            S_MM_START:  state_nxt = S_MM_LOAD;
            S_MM_LOAD:   if (wcnt == LAST) state_nxt = S_MM_WAIT;
            S_MM_WAIT:   if (mm_acc && rcnt == LAST) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt = S_IDLE;
        end
    end

    // wcnt indexes operand loads and MM buffer reads; rcnt indexes result words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            rcnt <= '0;
        end else if (is_start) begin
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            if ((in_acc || mm_rd) && wcnt != LAST) wcnt <= wcnt + 1'b1;
            if ((me_wr || mm_acc) && rcnt != LAST) rcnt <= rcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            me_x      <= '0;
            me_y      <= '0;
            me_strobe <= 1'b0;
            mm_strobe <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (in_acc) begin
                me_x <= in_x;
                me_y <= in_y;
            end
            me_strobe <= in_acc;
            mm_strobe <= mm_rd;
            if (mm_acc) begin
                out_data <= mm_result;
            end
            out_valid <= mm_acc;
            out_last  <= mm_acc && (rcnt == LAST);
        end
    end

    assign me_x_valid = me_strobe;
    assign me_y_valid = me_strobe;
    assign mm_x_valid = mm_strobe;
    assign mm_y_valid = mm_strobe;

    paillier_word_buf #(.K(K), .N(N), .AW(CW)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (me_wr && (state == S_ME1_WAIT)),
        .wr_addr (rcnt),
        .wr_data (me_result),
        .rd_en   (mm_rd),
        .rd_addr (wcnt),
        .rd_data (mm_x)
    );

    paillier_word_buf #(.K(K), .N(N), .AW(CW)) u_buf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (me_wr && (state == S_ME2_WAIT)),
        .wr_addr (rcnt),
        .wr_data (me_result),
        .rd_en   (mm_rd),
        .rd_addr (wcnt),
        .rd_data (mm_y)
    );

`ifdef PAILLIER_ENC_SCHED_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        in_wait;

    assign in_wait = (state == S_ME1_WAIT) || (state == S_ME2_WAIT) || (state == S_MM_WAIT);
    // Fires on the TIMEOUT_CYCLES-th consecutive strobe-free cycle of a WAIT state.
    assign timeout = in_wait && !me_wr && !mm_acc && (tcnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= timeout;
            if (!in_wait || (state_nxt != state) || me_wr || mm_acc) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 32'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_paillier_enc_sched.sv
// tb/tb_paillier_enc_sched.sv - directed self-checking bench for paillier_enc_sched (N=4)
module tb_paillier_enc_sched;

    localparam int K = 128;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         task_start = 1'b0;
    logic         busy;
    logic [K-1:0] in_x = '0;
    logic [K-1:0] in_y = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   state_now;
    logic         me_start;
    logic [K-1:0] me_x, me_y;
    logic         me_x_valid, me_y_valid;
    logic [K-1:0] me_result = '0;
    logic         me_valid = 1'b0;
    logic         mm_start;
    logic [K-1:0] mm_x, mm_y;
    logic         mm_x_valid, mm_y_valid;
    logic [K-1:0] mm_result = '0;
    logic         mm_valid = 1'b0;
    logic [K-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    paillier_enc_sched #(
        .K(K),
        .N(N)
`ifdef PAILLIER_ENC_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .task_start (task_start),
        .busy       (busy),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_now  (state_now),
        .me_start   (me_start),
        .me_x       (me_x),
        .me_y       (me_y),
        .me_x_valid (me_x_valid),
        .me_y_valid (me_y_valid),
        .me_result  (me_result),
        .me_valid   (me_valid),
        .mm_start   (mm_start),
        .mm_x       (mm_x),
        .mm_y       (mm_y),
        .mm_x_valid (mm_x_valid),
        .mm_y_valid (mm_y_valid),
        .mm_result  (mm_result),
        .mm_valid   (mm_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .err        (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] op_x(input int ph, input int i);
        logic [127:0] v;
        v = 128'h1000 * (ph + 1) + 128'(i);
        return v;
    endfunction

    function automatic logic [127:0] op_y(input int ph, input int i);
        logic [127:0] v;
        v = 128'h2000 * (ph + 1) + 128'(i);
        return v;
    endfunction

    task automatic start_job();
        task_start = 1'b1;
        step();
        task_start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    // Entered while sampling xx_START; leaves in the next START state (or in WAIT if !res).
    task automatic me_phase(input int ph, input bit gap, input bit ts_inj, input bit res);
        int strobes = 0;
        chk("me_st_state", state_now, ph == 0 ? 1 : 4);
        chk("me_st_pulse", me_start, 1);
        chk("me_st_rdy", in_ready, 0);
        step();
        chk("me_ld_state", state_now, ph == 0 ? 2 : 5);
        chk("me_ld_pulse", me_start, 0);
        chk("me_ld_rdy", in_ready, 1);
        for (int i = 0; i < N; i++) begin
            in_x = op_x(ph, i);
            in_y = op_y(ph, i);
            in_valid = 1'b1;
            step();
            strobes += int'(me_x_valid);
            chk("me_x", me_x, op_x(ph, i));
            chk("me_y", me_y, op_y(ph, i));
            chk("me_y_valid", me_y_valid, me_x_valid);
            if (gap) begin
                in_valid = 1'b0;
                in_x = '1;
                in_y = '1;
                if (i < N - 1) chk("gap_rdy", in_ready, 1);
                step();
                strobes += int'(me_x_valid);
            end
        end
        in_valid = 1'b0;
        chk("me_wait_state", state_now, ph == 0 ? 3 : 6);
        chk("me_wait_rdy", in_ready, 0);
        if (!gap) begin
            step();
            strobes += int'(me_x_valid);
        end
        chk("me_strobes", strobes, N);
        if (res) begin
            for (int i = 0; i < N; i++) begin
                me_valid = 1'b1;
                me_result = 128'(ph * 4 + i + 1);
                if (ts_inj && i == 1) task_start = 1'b1;
                step();
                task_start = 1'b0;
                if (i < N - 1) chk("me_res_state", state_now, ph == 0 ? 3 : 6);
            end
            me_valid = 1'b0;
            chk("me_next_state", state_now, ph == 0 ? 4 : 7);
        end
    endtask

    // Entered while sampling MM_START; abort>=0 asserts reset after that MM word.
    task automatic mm_phase(input bit spur, input int abort);
        chk("mm_st_state", state_now, 7);
        chk("mm_st_pulse", mm_start, 1);
        if (spur) begin
            me_valid = 1'b1;
            me_result = 128'hdead;
        end
        step();
        chk("mm_ld_state", state_now, 8);
        chk("mm_ld_pulse", mm_start, 0);
        for (int i = 0; i < N; i++) begin
            step();
            me_valid = 1'b0;
            chk("mm_valid", {mm_x_valid, mm_y_valid}, 2'b11);
            chk("mm_x", mm_x, 128'(i + 1));
            chk("mm_y", mm_y, 128'(i + 5));
            if (i == abort) begin
                chk("abort_state", state_now, 8);
                rst_n = 1'b0;
                #1;
                chk("rst_state", state_now, 0);
                chk("rst_busy", busy, 0);
                chk("rst_mm_valid", mm_x_valid, 0);
                chk("rst_mm_x", mm_x, 0);
                chk("rst_out_valid", out_valid, 0);
                return;
            end
        end
        chk("mm_wait_state", state_now, 9);
        step();
        chk("mm_valid_end", mm_x_valid, 0);
        for (int i = 0; i < N; i++) begin
            mm_valid = 1'b1;
            mm_result = 128'(i + 9);
            if (i == N - 1) task_start = 1'b1;
            step();
            task_start = 1'b0;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, 128'(i + 9));
            chk("out_last", out_last, i == N - 1);
        end
        mm_valid = 1'b0;
        chk("end_state", state_now, 0);
        chk("end_busy_hold", busy, 1);
        step();
        chk("end_busy_low", busy, 0);
        chk("end_out_valid", out_valid, 0);
        chk("end_state_idle", state_now, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_state_now", state_now, 0);
        chk("rst_outs", {busy, in_ready, me_start, me_x_valid, me_y_valid, mm_start,
                         mm_x_valid, mm_y_valid, out_valid, out_last, err}, 11'b0);
        chk("rst_words", me_x | me_y | mm_x | mm_y | out_data, 0);
        rst_n = 1'b1;
        step();
        chk("idle_state", state_now, 0);

        start_job();
        me_phase(0, 1'b0, 1'b0, 1'b1);
        me_phase(1, 1'b0, 1'b0, 1'b1);
        mm_phase(1'b0, -1);

        start_job();
        me_phase(0, 1'b1, 1'b0, 1'b1);
        me_phase(1, 1'b1, 1'b1, 1'b1);
        mm_phase(1'b1, -1);

        start_job();
        me_phase(0, 1'b0, 1'b0, 1'b1);
        me_phase(1, 1'b0, 1'b0, 1'b1);
        mm_phase(1'b0, 2);
        step();
        chk("rst_hold_state", state_now, 0);
        rst_n = 1'b1;
        step();

        start_job();
        me_phase(0, 1'b0, 1'b0, 1'b1);
        me_phase(1, 1'b0, 1'b0, 1'b1);
        mm_phase(1'b0, -1);
        chk("err_default", err, 0);

`ifdef PAILLIER_ENC_SCHED_TIMEOUT_EN
        begin
            int n;
            start_job();
            me_phase(0, 1'b0, 1'b0, 1'b0);
            n = 1;
            while (!err && n < 300) begin
                step();
                n++;
            end
            chk("to_cycles", 128'(n), 100);
            chk("to_err", err, 1);
            chk("to_state", state_now, 0);
            chk("to_busy", busy, 0);
            chk("to_last", out_last, 0);
            step();
            chk("to_err_pulse", err, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paillier_enc_sched.md
Name: paillier_enc_sched

Overview:
- Upstream sequencer for the shared ME/MM Montgomery datapath.
- Computes the Paillier ciphertext c = (g^m mod n²)·(r^n mod n²) mod n² as three operations in order: ME1 = g^m, ME2 = r^n, MM = ME1·ME2.
- Streams operand word pairs from a host-side source into the ME port, buffers both ME results internally, then replays them into the MM port.
- Forwards MM result words as the ciphertext stream and drives the datapath's state_now.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand, low word first.
- TIMEOUT_CYCLES, 2**20, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- task_start  in  1  one-cycle pulse; begins a job when idle.
- busy  out  1  high from accepted task_start until the last ciphertext word.
- in_x  in  K  operand word: g during ME1, r during ME2.
- in_y  in  K  exponent word: m during ME1, n during ME2.
- in_valid  in  1  in_x/in_y valid.
- in_ready  out  1  word pair accepted when in_valid && in_ready.
- state_now  out  4  current FSM state code, to the datapath top.
- me_start  out  1  ME start pulse.
- me_x, me_y  out  K  ME operand words.
- me_x_valid, me_y_valid  out  1  ME operand strobes, always equal.
- me_result  in  K  ME result word.
- me_valid  in  1  ME result word strobe.
- mm_start  out  1  MM start pulse.
- mm_x, mm_y  out  K  MM operand words.
- mm_x_valid, mm_y_valid  out  1  MM operand strobes, always equal.
- mm_result  in  K  MM result word.
- mm_valid  in  1  MM result word strobe.
- out_data  out  K  ciphertext word.
- out_valid  out  1  ciphertext strobe; no backpressure.
- out_last  out  1  marks word N-1.
- err  out  1  one-cycle timeout pulse; driven 0 when the feature is off.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- State codes:
  - IDLE=0
  - ME1_START=1, ME1_LOAD=2, ME1_WAIT=3
  - ME2_START=4, ME2_LOAD=5, ME2_WAIT=6
  - MM_START=7, MM_LOAD=8, MM_WAIT=9
- state_now is the registered state.
- IDLE: task_start → ME1_START. task_start in any other state is ignored.
- xx_START: me_start (or mm_start) high for exactly one cycle, then → xx_LOAD.
- ME LOAD:
  - in_ready=1.
  - Each accepted pair is registered onto me_x/me_y with me_x_valid=me_y_valid=1 the next cycle; latency 1.
  - Word counter wcnt increments on accept; after accept at wcnt=N-1 → WAIT, in_ready drops the same cycle.
- in_ready=0 in every state except ME1_LOAD and ME2_LOAD.
- ME WAIT:
  - Each me_valid writes me_result into buffer A (ME1) or B (ME2) at rcnt; rcnt increments.
  - After word N-1: ME1_WAIT → ME2_START; ME2_WAIT → MM_START.
  - me_valid outside WAIT is dropped. rcnt never exceeds N-1.
- MM_LOAD:
  - Reads A[i] and B[i] for i=0..N-1 on consecutive cycles, no gaps.
  - mm_x=A[i], mm_y=B[i], strobes high; buffer read latency 1 → mm strobes lag the read address by 1 cycle.
  - After word N-1 → MM_WAIT.
- MM_WAIT:
  - Each mm_valid drives out_data=mm_result, out_valid=1 on the next cycle.
  - out_last=1 on word N-1; then → IDLE.
  - busy falls the cycle after out_last.
- Counters: wcnt and rcnt are $clog2(N) bits; they clear on every START state and never wrap mid-phase.
- Simultaneous events: in MM_WAIT, task_start in the same cycle as the last mm_valid is ignored. A new job needs task_start while in IDLE.
- Reset mid-operation returns to IDLE immediately. Buffer contents are don't-care afterwards.

Optional Feature:
- Macro: PAILLIER_ENC_SCHED_TIMEOUT_EN.
- With it:
  - A cycle counter runs in ME1_WAIT, ME2_WAIT and MM_WAIT, cleared on every result strobe and every state change.
  - When it reaches TIMEOUT_CYCLES: err pulses 1 cycle, FSM → IDLE, busy → 0, no out_last.
- Without it: no counter, err tied 0, WAIT states wait indefinitely.

Decomposition:
- Package paillier_sched_pkg holds:
  - typedef enum logic [3:0] sched_state_t with the codes above.
  - localparam defaults for K and N.
- Sub-module paillier_word_buf: a 1W1R buffer of N×K bits with 1-cycle read latency. It is instantiated twice, for A and B.

Test Plan:
- Reset check: K=128, N=4; assert rst_n low → all outputs 0, state_now=0.
- Basic job: task_start, feed 4 pairs back-to-back, model returns results A={1,2,3,4}, B={5,6,7,8} → mm stream pairs (1,5)(2,6)(3,7)(4,8) on 4 consecutive cycles; MM results {9,10,11,12} → out_data 9..12 with out_last on 12; busy low one cycle later.
- Gapped input: in_valid toggling 1-0-1 → me strobes only on accepted words; exactly 4 per ME phase; in_ready=0 in ME1_WAIT.
- task_start during ME2_WAIT → ignored, state sequence unchanged. A spurious me_valid in MM_LOAD → buffers unchanged.
- Reset mid-operation: rst_n asserted in MM_LOAD after word 2 → outputs 0 at once; a fresh full job afterwards matches the expected output.
- Timeout, with PAILLIER_ENC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100: withhold me_valid in ME1_WAIT → err pulse at cycle 100, state_now=0, busy=0.
